// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and sizing helper for the serial subtractor
package serial_sub_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width of the bit counter that walks 0 .. width-1
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit full subtractor cell (d = x - y - bin)
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of one subtractor stage
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor with start/busy/done handshake
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             accept;
  logic             last_bit;
  logic             cell_d;
  logic             cell_bout;

  // A request is only honoured when no subtraction is in flight
  assign accept   = start && (state_q != ST_RUN);
  assign last_bit = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  // The one and only arithmetic cell, fed with the current LSBs and running borrow
  full_subtractor u_cell (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE behaves like IDLE for a new request (back-to-back)
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last_bit) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = accept ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next state: load on accept, shift one bit per RUN cycle, publish on the last bit
  always_comb begin
    sa_d     = sa_q;
    sb_d     = sb_q;
    br_d     = br_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    if (accept) begin
      sa_d  = a;
      sb_d  = b;
      br_d  = bin;
      res_d = '0;
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      sa_d  = {1'b0, sa_q[WIDTH-1:1]};
      sb_d  = {1'b0, sb_q[WIDTH-1:1]};
      br_d  = cell_bout;
      res_d = {cell_d, res_q[WIDTH-1:1]};
      cnt_d = cnt_q + CW'(1);
      if (last_bit) begin
        diff_d   = {cell_d, res_q[WIDTH-1:1]};
        borrow_d = cell_bout;
      end
    end
  end

  // Datapath registers; reset also discards any partial result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa_q     <= '0;
      sb_q     <= '0;
      br_q     <= 1'b0;
      res_q    <= '0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      br_q     <= br_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       borrow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] ed;
    logic       eb;
  } vec_t;

  vec_t vecs[7];

  serial_subtractor #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Launch one operation and follow it to done; all sampling on negedges
  task automatic do_op(input logic [3:0] va, input logic [3:0] vb, input logic vbin,
                       input logic [3:0] ed, input logic eb, input string nm);
    int lat;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; a = va; b = vb; bin = vbin;
    @(negedge clk);
    start = 1'b0; a = 4'hx; b = 4'hx; bin = 1'bx;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    chk({nm, " done_seen"}, done, 1'b1);
    chk({nm, " latency"}, lat, 5);
    chk({nm, " busy_cycles"}, busy_cnt, 4);
    chk({nm, " diff"}, diff, ed);
    chk({nm, " borrow"}, borrow, eb);
    @(negedge clk);
    chk({nm, " done_pulse_width"}, done, 1'b0);
    chk({nm, " diff_held"}, diff, ed);
  endtask

  initial begin
    int k;
    int done_cnt;
    int done_at;
    int hold_bad;
    logic [3:0] cap_d;
    logic cap_b;

    vecs[0] = '{4'b1011, 4'b0100, 1'b0, 4'b0111, 1'b0};
    vecs[1] = '{4'b0100, 4'b1011, 1'b0, 4'b1001, 1'b1};
    vecs[2] = '{4'b1001, 4'b0110, 1'b1, 4'b0010, 1'b0};
    vecs[3] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1};
    vecs[4] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0};
    vecs[5] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0};
    vecs[6] = '{4'b0101, 4'b0101, 1'b1, 4'b1111, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = 4'h0; b = 4'h0; bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset diff", diff, 4'h0);
    chk("reset borrow", borrow, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].ed, vecs[i].eb,
            $sformatf("vec%0d", i));
    end

    // start pulsed while busy must be ignored
    @(negedge clk);
    start = 1'b1; a = 4'b1111; b = 4'b1100; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; done_at = 0; cap_d = 4'h0; cap_b = 1'b0;
    for (k = 1; k <= 14; k++) begin
      if (k == 2) begin
        start = 1'b1; a = 4'b0001; b = 4'b0010; bin = 1'b0;
      end
      if (k == 3) start = 1'b0;
      if (done) begin
        done_cnt++;
        done_at = k;
        cap_d = diff;
        cap_b = borrow;
      end
      @(negedge clk);
    end
    chk("ign done_count", done_cnt, 1);
    chk("ign done_cycle", done_at, 5);
    chk("ign diff", cap_d, 4'b0011);
    chk("ign borrow", cap_b, 1'b0);

    // back-to-back: new request accepted in the DONE cycle
    @(negedge clk);
    start = 1'b1; a = 4'b1011; b = 4'b0100; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b2b first_latency", k, 5);
    chk("b2b first_diff", diff, 4'b0111);
    start = 1'b1; a = 4'b1011; b = 4'b1100; bin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    hold_bad = 0;
    while (!done && k < 20) begin
      if (diff !== 4'b0111 || borrow !== 1'b0) hold_bad++;
      @(negedge clk);
      k++;
    end
    chk("b2b second_latency", k, 5);
    chk("b2b first_result_held", hold_bad, 0);
    chk("b2b diff", diff, 4'b1110);
    chk("b2b borrow", borrow, 1'b1);
    @(negedge clk);

    // reset during RUN aborts the operation
    @(negedge clk);
    start = 1'b1; a = 4'b0110; b = 4'b0001; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst precondition busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst diff", diff, 4'h0);
    chk("rst borrow", borrow, 1'b0);
    done_cnt = 0;
    for (int j = 0; j < 8; j++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    chk("rst no_activity", done_cnt, 0);
    do_op(4'b0110, 4'b0001, 1'b0, 4'b0101, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
